// File: rtl/ddr_rd_unpack_pkg.sv
// Shared definitions for the DDR read unpack path: FSM state encoding,
// default lane count, burst byte stride and the lane ordering helper.
// Lane order is selected by DDR_RD_UNPACK_MSB_FIRST_EN (undefined: lane 0
// comes from the least significant 32 bits of each read word).
package ddr_rd_unpack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Defaults for the 256-bit DDR word / 32-bit stream configuration.
    localparam int LANES        = 256 / 32;
    localparam int BURST_STRIDE = 16 * (256 / 8);

    // Bytes covered by one burst request.
    function automatic int burst_stride(input int burst_len, input int in_width);
        return burst_len * (in_width / 8);
    endfunction

    // Maps the output lane sequence number to the lane position in the word.
    function automatic int lane_select(input int lane, input int lanes);
`ifdef DDR_RD_UNPACK_MSB_FIRST_EN
        return lanes - 1 - lane;
`else
        return lane - 0 * lanes;
`endif
    endfunction

endpackage

// File: rtl/ddr_rd_unpack_buf.sv
// Circular buffer of wide DDR read words. Exposes the head word and the
// word behind it so the unpacker can move to the next word without a bubble.
module ddr_rd_unpack_buf
    import ddr_rd_unpack_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [WIDTH-1:0]           next_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic             do_push;
    logic             do_pop;

    assign full      = (level == LVL_W'(DEPTH));
    assign do_push   = push & ~full;
    assign do_pop    = pop & (level != '0);
    assign rd_ptr_nx = rd_ptr + 1'b1;
    assign head_data = mem[rd_ptr];
    assign next_data = mem[rd_ptr_nx];

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr_nx;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ddr_rd_unpack.sv
// Frame reader: issues credit-limited burst reads, buffers returned wide
// words and unpacks them into a 32-bit valid/ready stream.
// Build option DDR_RD_UNPACK_MSB_FIRST_EN: output the top lane of each word first.
module ddr_rd_unpack
    import ddr_rd_unpack_pkg::*;
#(
    parameter int                    IN_WIDTH     = 256,
    parameter int                    OUT_WIDTH    = 32,
    parameter int                    ADDR_WIDTH   = 28,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    BURST_LEN    = 16,
    parameter int                    FRAME_BURSTS = 64,
    parameter int                    DEPTH        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      rd_req,
    output logic [ADDR_WIDTH-1:0]     rd_req_addr,
    output logic [7:0]                rd_req_len,
    input  logic                      rd_req_ack,
    input  logic                      ddr_rd_valid,
    input  logic [IN_WIDTH-1:0]       ddr_rd_data,
    output logic                      out_valid,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    buf_level,
    output logic                      ovf
);

    localparam int N_LANES    = IN_WIDTH / OUT_WIDTH;
    localparam int LANE_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int LVL_W      = $clog2(DEPTH) + 1;
    localparam int TOTAL_WIDE = BURST_LEN * FRAME_BURSTS;
    localparam int WCNT_W     = $clog2(TOTAL_WIDE + 1);
    localparam int BCNT_W     = $clog2(FRAME_BURSTS + 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(burst_stride(BURST_LEN, IN_WIDTH));

    state_t                state;
    logic [BCNT_W-1:0]     burst_cnt;
    logic [LVL_W-1:0]      outstanding;
    logic [LVL_W-1:0]      outstanding_nx;
    logic [LANE_W-1:0]     lane;
    logic [LANE_W-1:0]     lane_n;
    logic [WCNT_W-1:0]     pops_done;
    logic [WCNT_W-1:0]     pops_n;
    logic [IN_WIDTH-1:0]   head_data;
    logic [IN_WIDTH-1:0]   next_data;
    logic [IN_WIDTH-1:0]   src_word;
    logic [OUT_WIDTH-1:0]  lane_word;
    logic                  full;
    logic                  beat_in;
    logic                  push;
    logic                  fire;
    logic                  last_lane;
    logic                  pop;
    logic                  avail;
    logic                  start_accept;
    logic                  ack_take;
    logic                  credit_ok;
    logic [LVL_W:0]        free_space;

    assign rd_req_len = 8'(BURST_LEN);

    ddr_rd_unpack_buf #(
        .WIDTH (IN_WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ddr_rd_data),
        .pop       (pop),
        .head_data (head_data),
        .next_data (next_data),
        .level     (buf_level),
        .full      (full)
    );

    // Handshake decode and selection of the word feeding the output register.
    always_comb begin
        start_accept = (state == ST_IDLE) & start;
        ack_take     = (state == ST_REQ) & rd_req_ack;
        beat_in      = ddr_rd_valid & busy;
        push         = beat_in & ~full;
        fire         = out_valid & out_ready;
        last_lane    = (lane == LANE_W'(N_LANES - 1));
        pop          = fire & last_lane;
        pops_n       = pops_done + WCNT_W'(pop);
        lane_n       = lane;
        if (fire) begin
            lane_n = last_lane ? '0 : lane + 1'b1;
        end
        avail    = 1'b0;
        src_word = head_data;
        if (pop) begin
            if (buf_level > LVL_W'(1)) begin
                avail    = 1'b1;
                src_word = next_data;
            end else if (push) begin
                avail    = 1'b1;
                src_word = ddr_rd_data;
            end
        end else begin
            if (buf_level != '0) begin
                avail = 1'b1;
            end else if (push) begin
                avail    = 1'b1;
                src_word = ddr_rd_data;
            end
        end
        lane_word = src_word[lane_select(int'(lane_n), N_LANES) * OUT_WIDTH +: OUT_WIDTH];
    end

    // Credit check: room for a whole burst beyond what is held or in flight.
    always_comb begin
        free_space = (LVL_W + 1)'(DEPTH) - ({1'b0, buf_level} + {1'b0, outstanding});
        credit_ok  = ~free_space[LVL_W] && (free_space >= (LVL_W + 1)'(BURST_LEN));
        outstanding_nx = outstanding;
        if (ack_take) outstanding_nx = outstanding_nx + LVL_W'(BURST_LEN);
        if (beat_in && outstanding != '0) outstanding_nx = outstanding_nx - 1'b1;
    end

    // Request sequencer: one burst per REQ visit, WAIT holds until credit frees.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            rd_req      <= 1'b0;
            rd_req_addr <= BASE_ADDR;
            burst_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        rd_req      <= 1'b1;
                        rd_req_addr <= BASE_ADDR;
                        burst_cnt   <= '0;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (rd_req_ack) begin
                        rd_req      <= 1'b0;
                        rd_req_addr <= rd_req_addr + STRIDE;
                        burst_cnt   <= burst_cnt + 1'b1;
                        state       <= (burst_cnt == BCNT_W'(FRAME_BURSTS - 1)) ? ST_DRAIN : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (credit_ok) begin
                        rd_req <= 1'b1;
                        state  <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (fire && out_last) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outstanding beat count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            ovf         <= 1'b0;
        end else begin
            outstanding <= start_accept ? '0 : outstanding_nx;
            if (beat_in && full) ovf <= 1'b1;
        end
    end

    // Output register: reloads whenever empty or the current word is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            lane      <= '0;
            pops_done <= '0;
        end else begin
            lane      <= lane_n;
            pops_done <= start_accept ? '0 : pops_n;
            if (!out_valid || out_ready) begin
                out_valid <= avail;
                out_last  <= avail && (pops_n == WCNT_W'(TOTAL_WIDE - 1)) &&
                             (lane_n == LANE_W'(N_LANES - 1));
                if (avail) out_data <= lane_word;
            end
        end
    end

endmodule

// File: tb/tb_ddr_rd_unpack.sv
// Directed bench for ddr_rd_unpack with a small DDR responder and a stream monitor.
module tb_ddr_rd_unpack;

    localparam int BL          = 16;
    localparam int FB          = 64;
    localparam int TOTAL_WORDS = 8 * BL * FB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         busy;
    logic         rd_req;
    logic [27:0]  rd_req_addr;
    logic [7:0]   rd_req_len;
    logic         rd_req_ack = 1'b0;
    logic         ddr_rd_valid = 1'b0;
    logic [255:0] ddr_rd_data = '0;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic         out_ready = 1'b0;
    logic [5:0]   buf_level;
    logic         ovf;

    logic         w_start = 1'b0;
    logic         w_busy;
    logic         w_rd_req;
    logic [27:0]  w_rd_req_addr;
    logic [7:0]   w_rd_req_len;
    logic         w_rd_req_ack = 1'b0;
    logic         w_ddr_rd_valid = 1'b0;
    logic [255:0] w_ddr_rd_data = '0;
    logic         w_out_valid;
    logic [31:0]  w_out_data;
    logic         w_out_last;
    logic         w_out_ready = 1'b1;
    logic [5:0]   w_buf_level;
    logic         w_ovf;

    int checks = 0;
    int errors = 0;

    bit          mon_en = 1'b0;
    int          widx;
    int          bad_data;
    int          first_bad;
    int          bad_last;
    bit          frame_done;
    bit          ovf_seen;
    bit          last_pending = 1'b0;
    logic        busy_after_last;
    logic [27:0] addrs[$];
    int          pending;

    always #5 clk = ~clk;

    ddr_rd_unpack dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .rd_req       (rd_req),
        .rd_req_addr  (rd_req_addr),
        .rd_req_len   (rd_req_len),
        .rd_req_ack   (rd_req_ack),
        .ddr_rd_valid (ddr_rd_valid),
        .ddr_rd_data  (ddr_rd_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .buf_level    (buf_level),
        .ovf          (ovf)
    );

    ddr_rd_unpack #(
        .BASE_ADDR    (28'hFFFFE00),
        .FRAME_BURSTS (2)
    ) dut_wrap (
        .clk          (clk),
        .rst          (rst),
        .start        (w_start),
        .busy         (w_busy),
        .rd_req       (w_rd_req),
        .rd_req_addr  (w_rd_req_addr),
        .rd_req_len   (w_rd_req_len),
        .rd_req_ack   (w_rd_req_ack),
        .ddr_rd_valid (w_ddr_rd_valid),
        .ddr_rd_data  (w_ddr_rd_data),
        .out_valid    (w_out_valid),
        .out_data     (w_out_data),
        .out_last     (w_out_last),
        .out_ready    (w_out_ready),
        .buf_level    (w_buf_level),
        .ovf          (w_ovf)
    );

    function automatic logic [255:0] mk_beat(input int k);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = {8'hA5, k[15:0], i[7:0]};
        return d;
    endfunction

    function automatic logic [31:0] exp_word(input int w);
        int k;
        int l;
        k = w / 8;
        l = w % 8;
`ifdef DDR_RD_UNPACK_MSB_FIRST_EN
        l = 7 - l;
`endif
        return {8'hA5, k[15:0], l[7:0]};
    endfunction

    function automatic logic [255:0] lane_beat(input int base);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(base + i);
        return d;
    endfunction

    function automatic logic [31:0] exp_lane(input int j);
        int l;
        l = j % 8;
`ifdef DDR_RD_UNPACK_MSB_FIRST_EN
        l = 7 - l;
`endif
        return 32'((j / 8) * 16 + l);
    endfunction

    // Stream and request monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (last_pending) begin
                busy_after_last = busy;
                last_pending    = 1'b0;
            end
            if (rd_req && rd_req_ack) addrs.push_back(rd_req_addr);
            if (ovf) ovf_seen = 1'b1;
            if (out_valid && out_ready) begin
                if (out_data !== exp_word(widx)) begin
                    if (bad_data == 0) first_bad = widx;
                    bad_data++;
                end
                if (out_last !== (widx == TOTAL_WORDS - 1)) bad_last++;
                if (out_last) begin
                    frame_done   = 1'b1;
                    last_pending = 1'b1;
                end
                widx++;
            end
        end
    end

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; rd_req_ack = 1'b0; ddr_rd_valid = 1'b0;
        w_start = 1'b0; w_rd_req_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_frame(input int ack_gap_max, input int beat_pct, input int ready_pct,
                             input int limit, output bit done);
        pending = 0; widx = 0; bad_data = 0; first_bad = -1; bad_last = 0;
        frame_done = 1'b0; ovf_seen = 1'b0; busy_after_last = 1'bx; addrs.delete();
        mon_en = 1'b1;
        fork
            begin : req_proc
                int issued = 0;
                int gap = 0;
                int cyc = 0;
                while (issued < FB && cyc < limit) begin
                    @(posedge clk); #1; cyc++;
                    if (rd_req_ack) begin
                        rd_req_ack = 1'b0;
                        issued++;
                        pending += BL;
                        gap = int'($urandom_range(ack_gap_max, 0));
                    end else if (rd_req) begin
                        if (gap == 0) rd_req_ack = 1'b1;
                        else gap--;
                    end
                end
                rd_req_ack = 1'b0;
            end
            begin : beat_proc
                int sent = 0;
                int cyc = 0;
                while (sent < FB * BL && cyc < limit) begin
                    @(posedge clk); #1; cyc++;
                    ddr_rd_valid = 1'b0;
                    if (pending > 0 && int'($urandom_range(99, 0)) < beat_pct) begin
                        ddr_rd_valid = 1'b1;
                        ddr_rd_data  = mk_beat(sent);
                        sent++;
                        pending--;
                    end
                end
                @(posedge clk); #1 ddr_rd_valid = 1'b0;
            end
            begin : ready_proc
                int cyc = 0;
                while (!frame_done && cyc < limit) begin
                    @(posedge clk); #1; cyc++;
                    out_ready = (int'($urandom_range(99, 0)) < ready_pct);
                end
            end
        join
        @(negedge clk);
        done = frame_done;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL rst_rd_req: got %b want 0", rd_req); end
        checks++; if (rd_req_addr !== 28'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", rd_req_addr); end
        checks++; if (rd_req_len !== 8'd16) begin errors++; $display("FAIL rst_len: got %0d want 16", rd_req_len); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        checks++; if (buf_level !== 6'd0) begin errors++; $display("FAIL rst_buf_level: got %0d want 0", buf_level); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_full_frame();
        bit done;
        reset_dut();
        out_ready = 1'b1;
        start_frame();
        checks++; if (rd_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL start_latency: rd_req=%b busy=%b want 1 1", rd_req, busy); end
        run_frame(0, 100, 100, 20000, done);
        mon_en = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL full_done: frame not finished, words=%0d want %0d", widx, TOTAL_WORDS); end
        checks++; if (widx != TOTAL_WORDS) begin errors++; $display("FAIL full_count: got %0d want %0d", widx, TOTAL_WORDS); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL full_data: %0d bad words, first at %0d", bad_data, first_bad); end
        checks++; if (bad_last != 0) begin errors++; $display("FAIL full_last: %0d words with wrong out_last", bad_last); end
        checks++; if (busy_after_last !== 1'b0) begin errors++; $display("FAIL full_busy_fall: got %b want 0", busy_after_last); end
        checks++; if (addrs.size() != FB) begin errors++; $display("FAIL full_req_count: got %0d want %0d", addrs.size(), FB); end
        else begin
            checks++; if (addrs[0] !== 28'h0) begin errors++; $display("FAIL addr0: got %h want 0", addrs[0]); end
            checks++; if (addrs[1] !== 28'h200) begin errors++; $display("FAIL addr1: got %h want 200", addrs[1]); end
            checks++; if (addrs[2] !== 28'h400) begin errors++; $display("FAIL addr2: got %h want 400", addrs[2]); end
            checks++; if (addrs[63] !== 28'h7E00) begin errors++; $display("FAIL addr63: got %h want 7e00", addrs[63]); end
        end
        checks++; if (ovf_seen) begin errors++; $display("FAIL full_ovf: got 1 want 0"); end
        checks++; if (buf_level !== 6'd0) begin errors++; $display("FAIL full_level_end: got %0d want 0", buf_level); end
    endtask

    task automatic test_lane_order();
        int bad = 0;
        int bubbles = 0;
        reset_dut();
        out_ready = 1'b1;
        start_frame();
        @(posedge clk); #1 rd_req_ack = 1'b1;
        @(posedge clk); #1 rd_req_ack = 1'b0;
        ddr_rd_valid = 1'b1; ddr_rd_data = lane_beat(0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lane_pre_valid: got %b want 0", out_valid); end
        @(posedge clk); #1 ddr_rd_data = lane_beat(16);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lane_latency: got %b want 1", out_valid); end
        checks++; if (out_data !== exp_lane(0)) begin errors++; $display("FAIL lane_first: got %h want %h", out_data, exp_lane(0)); end
        for (int j = 0; j < 16; j++) begin
            if (out_valid !== 1'b1) bubbles++;
            if (out_data !== exp_lane(j)) bad++;
            @(posedge clk); #1;
            if (j == 0) ddr_rd_valid = 1'b0;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL lane_sequence: %0d wrong words of 16", bad); end
        checks++; if (bubbles != 0) begin errors++; $display("FAIL lane_bubble: %0d idle cycles want 0", bubbles); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lane_drained: out_valid=%b want 0", out_valid); end
        checks++; if (buf_level !== 6'd0) begin errors++; $display("FAIL lane_level: got %0d want 0", buf_level); end
    endtask

    task automatic test_backpressure_ovf();
        bit done;
        reset_dut();
        out_ready = 1'b0;
        start_frame();
        run_frame(0, 100, 0, 300, done);
        mon_en = 1'b0;
        checks++; if (addrs.size() != 2) begin errors++; $display("FAIL bp_requests: got %0d want 2", addrs.size()); end
        checks++; if (ovf_seen) begin errors++; $display("FAIL bp_ovf: got 1 want 0"); end
        checks++; if (buf_level !== 6'd32) begin errors++; $display("FAIL bp_level: got %0d want 32", buf_level); end
        checks++; if (out_valid !== 1'b1 || out_data !== exp_word(0)) begin errors++; $display("FAIL bp_hold: valid=%b data=%h want 1 %h", out_valid, out_data, exp_word(0)); end
        @(posedge clk); #1 ddr_rd_valid = 1'b1; ddr_rd_data = mk_beat(999);
        @(posedge clk); #1 ddr_rd_valid = 1'b0;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
        checks++; if (buf_level !== 6'd32) begin errors++; $display("FAIL ovf_level: got %0d want 32", buf_level); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        reset_dut();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    endtask

    task automatic test_random();
        bit done;
        reset_dut();
        start_frame();
        run_frame(3, 60, 50, 60000, done);
        mon_en = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL rand_done: words=%0d want %0d", widx, TOTAL_WORDS); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL rand_data: %0d bad words, first at %0d", bad_data, first_bad); end
        checks++; if (bad_last != 0) begin errors++; $display("FAIL rand_last: %0d wrong out_last", bad_last); end
        checks++; if (ovf_seen) begin errors++; $display("FAIL rand_ovf: got 1 want 0"); end
        checks++; if (busy_after_last !== 1'b0) begin errors++; $display("FAIL rand_busy_fall: got %b want 0", busy_after_last); end
    endtask

    task automatic test_rst_midframe();
        bit done;
        int stray_bad = 0;
        reset_dut();
        start_frame();
        run_frame(1, 80, 100, 150, done);
        mon_en = 1'b0;
        @(posedge clk); #1 rst = 1'b1; ddr_rd_valid = 1'b1; ddr_rd_data = mk_beat(77);
        @(posedge clk); #1 rst = 1'b0;
        checks++; if (busy !== 1'b0 || rd_req !== 1'b0 || rd_req_addr !== 28'h0) begin errors++; $display("FAIL midrst_ctrl: busy=%b rd_req=%b addr=%h want 0 0 0", busy, rd_req, rd_req_addr); end
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin errors++; $display("FAIL midrst_out: valid=%b data=%h last=%b want 0 0 0", out_valid, out_data, out_last); end
        checks++; if (buf_level !== 6'd0 || ovf !== 1'b0) begin errors++; $display("FAIL midrst_buf: level=%0d ovf=%b want 0 0", buf_level, ovf); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (buf_level !== 6'd0 || out_valid !== 1'b0 || ovf !== 1'b0) stray_bad++;
        end
        ddr_rd_valid = 1'b0;
        checks++; if (stray_bad != 0) begin errors++; $display("FAIL stray_beats: %0d cycles with state change want 0", stray_bad); end
        start_frame();
        run_frame(2, 70, 100, 30000, done);
        mon_en = 1'b0;
        checks++; if (!done || widx != TOTAL_WORDS) begin errors++; $display("FAIL rerun_count: got %0d want %0d", widx, TOTAL_WORDS); end
        checks++; if (bad_data != 0) begin errors++; $display("FAIL rerun_data: %0d bad words, first at %0d", bad_data, first_bad); end
    endtask

    task automatic test_addr_wrap();
        int n = 0;
        reset_dut();
        @(posedge clk); #1 w_start = 1'b1;
        @(posedge clk); #1 w_start = 1'b0;
        checks++; if (w_rd_req !== 1'b1 || w_rd_req_addr !== 28'hFFFFE00) begin errors++; $display("FAIL wrap_first: req=%b addr=%h want 1 ffffe00", w_rd_req, w_rd_req_addr); end
        w_rd_req_ack = 1'b1;
        @(posedge clk); #1 w_rd_req_ack = 1'b0;
        while (w_rd_req !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (w_rd_req !== 1'b1) begin errors++; $display("FAIL wrap_second_req: no request within %0d cycles", n); end
        checks++; if (w_rd_req_addr !== 28'h0) begin errors++; $display("FAIL wrap_second_addr: got %h want 0", w_rd_req_addr); end
        reset_dut();
    endtask

    initial begin
        test_reset();
        test_lane_order();
        test_addr_wrap();
        test_full_frame();
        test_backpressure_ovf();
        test_random();
        test_rst_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
